rptr_empty_sync: RTL and testbench
==================================

Name: rptr_empty_sync

Overview:
- Read-domain pointer and flag block for the dual-clock FIFO. Parametrised successor to the fixed-style read-pointer/empty logic.
- Adds the following:
  - internal N-stage synchroniser for the write Gray pointer
  - binary RAM address
  - registered fill level
  - programmable almost-empty flag
  - sticky underflow flag
- Sits between the read-side consumer, the FIFO memory read port, and the write-domain full logic, which receives rptr.

Parameters:
- ADDRSIZE, 4, memory address width; depth = 2**ADDRSIZE; pointers are ADDRSIZE+1 bits.
- SYNC_STAGES, 2, flops in the wptr synchroniser; legal values 2..4.
- AE_RESET, 1, value loaded into the almost-empty threshold register at reset.

Ports:
- rclk, input, 1, read clock; all logic is posedge.
- rrst_n, input, 1, asynchronous active-low reset.
- rinc, input, 1, read request; consumes one word when not empty.
- wptr_gray, input, ADDRSIZE+1, write Gray pointer from the write domain (asynchronous to rclk).
- ae_thresh_wr, input, 1, load ae_thresh_in into the threshold register.
- ae_thresh_in, input, ADDRSIZE+1, new almost-empty threshold.
- rundf_clr, input, 1, clear the sticky underflow flag.
- raddr, output, ADDRSIZE, memory read address (binary).
- rptr, output, ADDRSIZE+1, registered read Gray pointer, sent to the write domain.
- rempty, output, 1, FIFO empty.
- raempty, output, 1, fill level <= threshold.
- rlevel, output, ADDRSIZE+1, words available (0..2**ADDRSIZE).
- rundf, output, 1, sticky: a read was attempted while empty.

Behaviour:
- Reset (async assert, sync-to-rclk deassert is external) sets:
  - sync flops = 0, rbin = 0, rptr = 0, rempty = 1, raempty = 1
  - rlevel = 0, rundf = 0, threshold = AE_RESET
- Synchroniser:
  - wptr_gray passes through SYNC_STAGES flops; the last stage is rwq.
  - No logic between stages.
- Next-pointer logic:
  - rd_en = rinc & ~rempty.
  - rbnext = rbin + rd_en, modulo 2**(ADDRSIZE+1).
  - rgnext = (rbnext >> 1) ^ rbnext.
- Pointer registers:
  - Each edge: rbin <= rbnext, rptr <= rgnext.
  - raddr = rbin[ADDRSIZE-1:0], combinational from the register, so valid in the same cycle as rempty.
- Empty flag:
  - rempty <= (rgnext == rwq).
  - Includes the read being done this cycle, so the last word read asserts rempty on the next edge. No bubble, no over-read.
- Level:
  - rwbin = gray-to-binary(rwq).
  - lvl = rwbin - rbnext, modulo 2**(ADDRSIZE+1).
  - rlevel <= lvl.
  - lvl never exceeds 2**ADDRSIZE given a correct write side; no saturation logic.
- Almost-empty:
  - raempty <= (lvl <= thresh), unsigned compare.
  - thresh = 0 makes raempty identical to rempty.
  - thresh >= 2**ADDRSIZE holds raempty at 1.
- Threshold register:
  - Loaded on ae_thresh_wr.
  - The new value takes effect in the flag computed on the edge after the load (one cycle later).
- Underflow:
  - rinc & rempty sets rundf on the next edge; the pointer does not move.
  - rundf_clr clears it.
  - If set and clear occur in the same cycle, set wins.
- Latency:
  - A write pointer change appears at rwq after SYNC_STAGES rclk edges.
  - rempty, raempty and rlevel reflect it one edge later: SYNC_STAGES+1 total.
  - rinc at edge k updates rptr, raddr and the flags at edge k.
- Wrap-around:
  - The pointer wraps from 2**(ADDRSIZE+1)-1 to 0.
  - Gray sequence stays single-bit-change across the wrap.
  - raddr wraps every 2**ADDRSIZE reads.
- Simultaneous events:
  - rinc while rwq advances in the same cycle: both are used in the same next-state computation; no lost update.
- Reset mid-operation: all state returns to reset values immediately, regardless of rclk.

Test Plan:
- Reset then idle, wptr_gray=0 → rempty=1, raempty=1, rlevel=0, rptr=0, raddr=0, rundf=0 for 10 cycles.
- Drive wptr_gray Gray(3), SYNC_STAGES=2 → rempty falls and rlevel=3 exactly 3 rclk edges later. Then 3 back-to-back rinc → raddr 0,1,2; rempty=1 at the edge consuming the third word; rptr=Gray(3)=5'b00010.
- Threshold 2, FIFO holding 4 words → raempty=0. After two reads, rlevel=2 and raempty=1. Load threshold 0 → raempty=0 one edge later.
- Fill and drain 40 words with ADDRSIZE=4, keeping level <=16 → rptr crosses 31→0 with one bit change per step, raddr wraps at 16, no spurious rempty.
- rinc held for 2 cycles while empty → rundf=1, rptr unchanged. Assert rundf_clr together with a new rinc on empty → rundf stays 1. rundf_clr alone → rundf=0.
- Level 8 with rinc active, then assert rrst_n=0 mid-cycle → outputs return to reset values asynchronously, before the next rclk. Release reset with wptr_gray=0 → rempty=1.

Source files
------------

// File: rtl/rptr_empty_sync_if.sv
// rptr_empty_sync_if: read-side bundle between the consumer/write domain (master)
// and the read pointer block (slave).
interface rptr_empty_sync_if #(
   parameter int ADDRSIZE = 4
);
   logic                rinc;
   logic [ADDRSIZE:0]   wptr_gray;
   logic                ae_thresh_wr;
   logic [ADDRSIZE:0]   ae_thresh_in;
   logic                rundf_clr;
   logic [ADDRSIZE-1:0] raddr;
   logic [ADDRSIZE:0]   rptr;
   logic                rempty;
   logic                raempty;
   logic [ADDRSIZE:0]   rlevel;
   logic                rundf;
   modport master (
      output rinc, wptr_gray, ae_thresh_wr, ae_thresh_in, rundf_clr,
      input  raddr, rptr, rempty, raempty, rlevel, rundf
   );
   modport slave (
      input  rinc, wptr_gray, ae_thresh_wr, ae_thresh_in, rundf_clr,
      output raddr, rptr, rempty, raempty, rlevel, rundf
   );
endinterface

// File: rtl/rptr_empty_sync.sv
// rptr_empty_sync: read-domain pointer, empty/almost-empty flags, fill level and
// sticky underflow for a dual-clock FIFO, with an internal write-pointer synchroniser.
module rptr_empty_sync #(
   parameter int ADDRSIZE    = 4,
   parameter int SYNC_STAGES = 2,
   parameter int AE_RESET    = 1
) (
   input logic              rclk,
   input logic              rrst_n,
   rptr_empty_sync_if.slave bus
);
   localparam int PW = ADDRSIZE + 1;
   logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
   logic [PW-1:0] rwq, rwbin, rbin, rptr_q, rbnext, rgnext, lvl, level_q, thresh;
   logic          rd_en, rempty_q, raempty_q, rundf_q;
   assign rwq = sync_q[SYNC_STAGES-1];
   // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      rwbin = '0;
      for (int i = 0; i < PW; i++) rwbin[i] = ^(rwq >> i);
   end
   assign rd_en  = bus.rinc & ~rempty_q;
   assign rbnext = rbin + PW'(rd_en);
   assign rgnext = (rbnext >> 1) ^ rbnext;
   assign lvl    = rwbin - rbnext;
   always_ff @(posedge rclk or negedge rrst_n)
      if (!rrst_n) begin
         sync_q    <= '0;
         rbin      <= '0;
         rptr_q    <= '0;
         rempty_q  <= 1'b1;
         raempty_q <= 1'b1;
         level_q   <= '0;
         rundf_q   <= 1'b0;
         thresh    <= PW'(AE_RESET);
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.wptr_gray};
         rbin      <= rbnext;
         rptr_q    <= rgnext;
         rempty_q  <= rgnext == rwq;
         raempty_q <= lvl <= thresh;
         level_q   <= lvl;
         rundf_q   <= (bus.rinc & rempty_q) | (rundf_q & ~bus.rundf_clr);
         thresh    <= bus.ae_thresh_wr ? bus.ae_thresh_in : thresh;
      end
   assign bus.raddr   = rbin[ADDRSIZE-1:0];
   assign bus.rptr    = rptr_q;
   assign bus.rempty  = rempty_q;
   assign bus.raempty = raempty_q;
   assign bus.rlevel  = level_q;
   assign bus.rundf   = rundf_q;
endmodule

// File: tb/tb_rptr_empty_sync.sv
// tb_rptr_empty_sync: directed checks of pointer, flags, level, threshold,
// underflow, wrap-around and asynchronous reset.
module tb_rptr_empty_sync;
   logic rclk = 1'b0, rrst_n = 1'b0;
   int   errors = 0, checks = 0, wb = 0, rb = 0;
   logic [4:0] prev;
   rptr_empty_sync_if #(.ADDRSIZE(4)) bus();
   rptr_empty_sync #(.ADDRSIZE(4), .SYNC_STAGES(2), .AE_RESET(1)) dut (
      .rclk(rclk), .rrst_n(rrst_n), .bus(bus)
   );
   always #5 rclk = ~rclk;
   function automatic int gray(int b);
      int x = b & 31;
      return x ^ (x >> 1);
   endfunction
   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic tick(input int n = 1);
      repeat (n) @(posedge rclk);
      #1;
   endtask
   task automatic chk_reset(input string tag);
      chk({tag, "_rempty"}, 32'(bus.rempty), 1);
      chk({tag, "_raempty"}, 32'(bus.raempty), 1);
      chk({tag, "_rlevel"}, 32'(bus.rlevel), 0);
      chk({tag, "_rptr"}, 32'(bus.rptr), 0);
      chk({tag, "_raddr"}, 32'(bus.raddr), 0);
      chk({tag, "_rundf"}, 32'(bus.rundf), 0);
   endtask
   initial begin
      bus.rinc = 0; bus.wptr_gray = '0; bus.ae_thresh_wr = 0; bus.ae_thresh_in = '0; bus.rundf_clr = 0;
      #12 rrst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk_reset("idle");
      end
      // three words arrive; visible after sync + flag edge
      wb = 3; bus.wptr_gray = 5'(gray(wb));
      tick(2);
      chk("lat2_rempty", 32'(bus.rempty), 1);
      tick();
      chk("lat3_rempty", 32'(bus.rempty), 0);
      chk("lat3_rlevel", 32'(bus.rlevel), 3);
      chk("lat3_raempty", 32'(bus.raempty), 0);
      for (int i = 0; i < 3; i++) begin
         chk("b2b_raddr", 32'(bus.raddr), i);
         bus.rinc = 1;
         tick();
         rb++;
         chk("b2b_rlevel", 32'(bus.rlevel), wb - rb);
         chk("b2b_rempty", 32'(bus.rempty), rb == 3 ? 1 : 0);
      end
      bus.rinc = 0;
      chk("b2b_rptr", 32'(bus.rptr), 2);
      // almost-empty threshold
      bus.ae_thresh_wr = 1; bus.ae_thresh_in = 5'd2;
      tick();
      bus.ae_thresh_wr = 0;
      wb = 7; bus.wptr_gray = 5'(gray(wb));
      tick(3);
      chk("ae_rlevel4", 32'(bus.rlevel), 4);
      chk("ae_lvl4", 32'(bus.raempty), 0);
      bus.rinc = 1;
      tick(); rb++;
      chk("ae_lvl3", 32'(bus.raempty), 0);
      tick(); rb++;
      bus.rinc = 0;
      chk("ae_rlevel2", 32'(bus.rlevel), 2);
      chk("ae_lvl2", 32'(bus.raempty), 1);
      bus.ae_thresh_wr = 1; bus.ae_thresh_in = 5'd0;
      tick();
      bus.ae_thresh_wr = 0;
      chk("ae_old_thresh", 32'(bus.raempty), 1);
      tick();
      chk("ae_new_thresh", 32'(bus.raempty), 0);
      chk("ae_new_rempty", 32'(bus.rempty), 0);
      // fill/drain 40 words across raddr and rptr wrap
      for (int c = 0; c < 4; c++) begin
         wb += 10; bus.wptr_gray = 5'(gray(wb));
         tick(3);
         while (rb < wb) begin
            chk("wrap_rlevel", 32'(bus.rlevel), wb - rb);
            chk("wrap_raddr", 32'(bus.raddr), rb & 15);
            chk("wrap_rempty", 32'(bus.rempty), 0);
            prev = bus.rptr;
            bus.rinc = 1;
            tick();
            rb++;
            chk("wrap_rptr", 32'(bus.rptr), gray(rb));
            chk("wrap_gray1bit", $countones(bus.rptr ^ prev), 1);
         end
         bus.rinc = 0;
         chk("wrap_drained", 32'(bus.rempty), 1);
      end
      // underflow
      chk("undf_pre", 32'(bus.rundf), 0);
      bus.rinc = 1;
      tick(2);
      chk("undf_set", 32'(bus.rundf), 1);
      chk("undf_rptr", 32'(bus.rptr), gray(rb));
      bus.rundf_clr = 1;
      tick();
      chk("undf_set_wins", 32'(bus.rundf), 1);
      bus.rinc = 0;
      tick();
      chk("undf_clr", 32'(bus.rundf), 0);
      bus.rundf_clr = 0;
      // asynchronous reset mid-cycle
      wb += 8; bus.wptr_gray = 5'(gray(wb));
      tick(3);
      chk("rst_rlevel8", 32'(bus.rlevel), 8);
      bus.rinc = 1;
      #3 rrst_n = 1'b0;
      #1 chk_reset("async");
      bus.rinc = 0; bus.wptr_gray = '0;
      #2 rrst_n = 1'b1;
      tick(2);
      chk("rel_rempty", 32'(bus.rempty), 1);
      chk("rel_rlevel", 32'(bus.rlevel), 0);
      // threshold back at its reset value, then held high by an oversized threshold
      bus.wptr_gray = 5'(gray(1));
      tick(3);
      chk("aer_rlevel1", 32'(bus.rlevel), 1);
      chk("aer_lvl1", 32'(bus.raempty), 1);
      chk("aer_rempty", 32'(bus.rempty), 0);
      bus.wptr_gray = 5'(gray(2));
      tick(3);
      chk("aer_lvl2", 32'(bus.raempty), 0);
      bus.ae_thresh_wr = 1; bus.ae_thresh_in = 5'd16;
      tick();
      bus.ae_thresh_wr = 0;
      tick();
      chk("ae_max", 32'(bus.raempty), 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
